alu_ext_seq: RTL and testbench

//  Sequencer for the multi-cycle extended ALU (MUL/UMUL/ADDF/SUBF/MULF/ITF/FTI).

---
 rtl/alu_ext_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_ext_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ext_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_ext_seq                                                   |
// | Purpose  : Sequencer for the multi-cycle extended ALU. Accepts one op at |
// |            a time, holds operands/func to the datapath for the op's      |
// |            latency, captures result/flags and stalls the pipeline until  |
// |            the result is consumed.                                       |
// | Config   : ALU_EXT_SEQ_PERF_EN adds perf_ops / perf_busy counters.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_ext_seq #(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned FADD_LAT = 4,
  parameter int unsigned FMUL_LAT = 4,
  parameter int unsigned CVT_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src0,
  input  logic [2:0]  req_func,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src0,
  output logic [2:0]  alu_func,
  input  logic [31:0] alu_dst,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_neg,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_dst,
  output logic        rsp_ov,
  output logic        rsp_zr,
  output logic        rsp_neg,
  output logic        rsp_ill,
  output logic        stall
`ifdef ALU_EXT_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
`endif
);

  localparam logic [2:0] C_FUNC_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src0_q, src0_d;
  logic [2:0]  func_q, func_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_dst_q, rsp_dst_d;
  logic        rsp_ov_q, rsp_ov_d;
  logic        rsp_zr_q, rsp_zr_d;
  logic        rsp_neg_q, rsp_neg_d;
  logic        rsp_ill_q, rsp_ill_d;
  logic        w_accept;

  // Counter preload: the counter hits zero in the last EXEC cycle.
  function automatic logic [3:0] lat_m1(input logic [2:0] func);
    case (func)
      3'b000, 3'b001: lat_m1 = 4'(MUL_LAT - 1);
      3'b010, 3'b011: lat_m1 = 4'(FADD_LAT - 1);
      3'b100:         lat_m1 = 4'(FMUL_LAT - 1);
      default:        lat_m1 = 4'(CVT_LAT - 1);
    endcase
  endfunction

  // In DONE a new op may be taken in the same cycle the result is consumed.
  assign req_rdy  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_rdy);
  assign stall    = (state_q == ST_EXEC) || ((state_q == ST_DONE) && !rsp_rdy);
  assign w_accept = req_vld && req_rdy;

  assign alu_src1 = src1_q;
  assign alu_src0 = src0_q;
  assign alu_func = func_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_dst  = rsp_dst_q;
  assign rsp_ov   = rsp_ov_q;
  assign rsp_zr   = rsp_zr_q;
  assign rsp_neg  = rsp_neg_q;
  assign rsp_ill  = rsp_ill_q;

  // Next-state: EXEC countdown/capture, DONE release, then accept overrides.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src1_d    = src1_q;
    src0_d    = src0_q;
    func_d    = func_q;
    rsp_vld_d = rsp_vld_q;
    rsp_dst_d = rsp_dst_q;
    rsp_ov_d  = rsp_ov_q;
    rsp_zr_d  = rsp_zr_q;
    rsp_neg_d = rsp_neg_q;
    rsp_ill_d = rsp_ill_q;

    case (state_q)
      ST_IDLE: ;
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_DONE;
          rsp_vld_d = 1'b1;
          rsp_dst_d = alu_dst;
          rsp_ov_d  = alu_ov;
          rsp_zr_d  = alu_zr;
          rsp_neg_d = alu_neg;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (rsp_rdy) begin
          state_d   = ST_IDLE;
          rsp_vld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      src1_d    = req_src1;
      src0_d    = req_src0;
      func_d    = req_func;
      rsp_ill_d = 1'b0;
      rsp_vld_d = 1'b0;
      if (req_func == C_FUNC_ILL) begin
        // Illegal op: no datapath run, zero result reported next cycle.
        state_d   = ST_DONE;
        cnt_d     = 4'd0;
        rsp_vld_d = 1'b1;
        rsp_dst_d = 32'd0;
        rsp_ov_d  = 1'b0;
        rsp_zr_d  = 1'b0;
        rsp_neg_d = 1'b0;
        rsp_ill_d = 1'b1;
      end else begin
        state_d = ST_EXEC;
        cnt_d   = lat_m1(req_func);
      end
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      src1_q    <= 32'd0;
      src0_q    <= 32'd0;
      func_q    <= 3'd0;
      rsp_vld_q <= 1'b0;
      rsp_dst_q <= 32'd0;
      rsp_ov_q  <= 1'b0;
      rsp_zr_q  <= 1'b0;
      rsp_neg_q <= 1'b0;
      rsp_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src1_q    <= src1_d;
      src0_q    <= src0_d;
      func_q    <= func_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dst_q <= rsp_dst_d;
      rsp_ov_q  <= rsp_ov_d;
      rsp_zr_q  <= rsp_zr_d;
      rsp_neg_q <= rsp_neg_d;
      rsp_ill_q <= rsp_ill_d;
    end
  end

`ifdef ALU_EXT_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;

  // Saturating counts of accepted ops and EXEC cycles.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if (w_accept && (perf_ops_q != 32'hFFFF_FFFF)) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end
    if ((state_q == ST_EXEC) && (perf_busy_q != 32'hFFFF_FFFF)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ext_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_ext_seq                                                |
// | Purpose  : Self-checking bench for alu_ext_seq with an emulated          |
// |            datapath and a behavioural result/latency model.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_ext_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_src1;
  logic [31:0] req_src0;
  logic [2:0]  req_func;
  logic [31:0] alu_src1;
  logic [31:0] alu_src0;
  logic [2:0]  alu_func;
  logic [31:0] alu_dst;
  logic        alu_ov;
  logic        alu_zr;
  logic        alu_neg;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_dst;
  logic        rsp_ov;
  logic        rsp_zr;
  logic        rsp_neg;
  logic        rsp_ill;
  logic        stall;
`ifdef ALU_EXT_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  always #5 clk = ~clk;

  alu_ext_seq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_src1 (req_src1),
    .req_src0 (req_src0),
    .req_func (req_func),
    .alu_src1 (alu_src1),
    .alu_src0 (alu_src0),
    .alu_func (alu_func),
    .alu_dst  (alu_dst),
    .alu_ov   (alu_ov),
    .alu_zr   (alu_zr),
    .alu_neg  (alu_neg),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_dst  (rsp_dst),
    .rsp_ov   (rsp_ov),
    .rsp_zr   (rsp_zr),
    .rsp_neg  (rsp_neg),
    .rsp_ill  (rsp_ill),
    .stall    (stall)
`ifdef ALU_EXT_SEQ_PERF_EN
    ,
    .perf_ops (perf_ops),
    .perf_busy(perf_busy)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit pending  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural arithmetic (single precision via real) ----
  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic int lat_of(input logic [2:0] fn);
    case (fn)
      3'd0, 3'd1: return 3;
      3'd2, 3'd3, 3'd4: return 4;
      3'd5, 3'd6: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] dp_res(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'd0: return 32'($signed(a) * $signed(b));
      3'd1: return 32'(a * b);
      3'd2: return r2f(f2r(a) + f2r(b));
      3'd3: return r2f(f2r(a) - f2r(b));
      3'd4: return r2f(f2r(a) * f2r(b));
      3'd5: return r2f(real'($signed(a)));
      3'd6: return 32'($rtoi(f2r(a)));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic dp_ov(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    p = longint'($signed(a)) * longint'($signed(b));
    u = {32'd0, a} * {32'd0, b};
    case (fn)
      3'd0: return !((p[63:31] == '0) || (p[63:31] == '1));
      3'd1: return (u[63:32] != 32'd0);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- emulated datapath: result valid only after LAT-1 cycles
  int          age = 1000;
  logic [31:0] dp_r;

  always @(posedge clk) begin
    if (rst_n && req_vld && req_rdy) age <= 0;
    else if (age < 1000) age <= age + 1;
  end

  always_comb begin
    dp_r = dp_res(alu_func, alu_src1, alu_src0);
    if (age == lat_of(alu_func) - 1) begin
      alu_dst = dp_r;
      alu_ov  = dp_ov(alu_func, alu_src1, alu_src0);
      alu_zr  = (dp_r == 32'd0);
      alu_neg = dp_r[31];
    end else begin
      alu_dst = dp_r ^ 32'hA5A5_5A5A;
      alu_ov  = ~dp_ov(alu_func, alu_src1, alu_src0);
      alu_zr  = (dp_r != 32'd0);
      alu_neg = ~dp_r[31];
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          n;
    logic [31:0] e_dst;
    logic        e_ill;
    e_ill = (fn == 3'b111);
    e_dst = e_ill ? 32'd0 : dp_res(fn, a, b);
    req_vld  = 1'b1;
    req_func = fn;
    req_src1 = a;
    req_src0 = b;
    rsp_rdy  = pending;
    #1;
    check("req_rdy_before_accept", req_rdy, 1'b1);
    @(posedge clk); #1;
    req_vld = 1'b0;
    rsp_rdy = 1'b0;
    pending = 1'b1;
    check("ill_after_accept", rsp_ill, e_ill);
    n = 0;
    while (!rsp_vld && n < 40) begin
      check("stall_exec", stall, 1'b1);
      check("req_rdy_exec", req_rdy, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_f%0d", fn), n, lat_of(fn));
    check($sformatf("dst_f%0d", fn), rsp_dst, e_dst);
    check("ov", rsp_ov, e_ill ? 1'b0 : dp_ov(fn, a, b));
    check("zr", rsp_zr, e_ill ? 1'b0 : (e_dst == 32'd0));
    check("neg", rsp_neg, e_ill ? 1'b0 : e_dst[31]);
    check("ill", rsp_ill, e_ill);
    repeat (hold) begin
      req_vld  = 1'b1;
      req_func = 3'($urandom);
      req_src1 = $urandom;
      req_src0 = $urandom;
      @(posedge clk); #1;
      check("hold_vld", rsp_vld, 1'b1);
      check("hold_dst", rsp_dst, e_dst);
      check("hold_stall", stall, 1'b1);
    end
    req_vld = 1'b0;
  endtask

  task automatic consume();
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    #1;
    check("stall_on_consume", stall, 1'b0);
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    pending = 1'b0;
    check("vld_after_consume", rsp_vld, 1'b0);
    check("rdy_after_consume", req_rdy, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = 1'b0;
    rsp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pending = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_rdy"}, req_rdy, 1'b1);
    check({tag, "_rsp_vld"}, rsp_vld, 1'b0);
    check({tag, "_rsp_ill"}, rsp_ill, 1'b0);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_rsp_dst"}, rsp_dst, 32'd0);
    check({tag, "_alu_src1"}, alu_src1, 32'd0);
    check({tag, "_alu_func"}, {29'd0, alu_func}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_func = 3'd0;
    req_src1 = 32'd0;
    req_src0 = 32'd0;
    do_reset();
    check_reset_state("reset");

    // Idle with no requests
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_rdy", req_rdy, 1'b1);
      check("idle_vld", rsp_vld, 1'b0);
      check("idle_stall", stall, 1'b0);
    end

    // MUL 7 * -3, held 5 cycles
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5);
    check("mul_dst", rsp_dst, 32'hFFFF_FFEB);
    check("mul_neg", rsp_neg, 1'b1);
    consume();

    // ADDF 1.0 + 2.0 then back-to-back SUBF
    run_op(3'd2, 32'h3F80_0000, 32'h4000_0000, 0);
    check("addf_dst", rsp_dst, 32'h4040_0000);
    run_op(3'd3, 32'h3F80_0000, 32'h4000_0000, 0);
    check("subf_dst", rsp_dst, 32'hBF80_0000);
    consume();

    // Illegal op, then ITF(5) clears rsp_ill
    run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    check("ill_flag", rsp_ill, 1'b1);
    run_op(3'd5, 32'd5, 32'd0, 0);
    check("itf_dst", rsp_dst, 32'h40A0_0000);
    check("itf_ill_cleared", rsp_ill, 1'b0);
    consume();

    // Reset in the middle of a MULF
    req_vld  = 1'b1;
    req_func = 3'd4;
    req_src1 = 32'h4000_0000;
    req_src0 = 32'h4040_0000;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pending = 1'b0;
    check_reset_state("midrst");
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", rsp_vld, 1'b0);
    end
    run_op(3'd6, 32'h40A0_0000, 32'd0, 1);
    check("fti_dst", rsp_dst, 32'd5);
    consume();

`ifdef ALU_EXT_SEQ_PERF_EN
    do_reset();
    check("perf_ops_reset", perf_ops, 32'd0);
    check("perf_busy_reset", perf_busy, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 0);
    consume();
    run_op(3'd2, 32'h3F80_0000, 32'h3F80_0000, 0);
    consume();
    run_op(3'd5, 32'd9, 32'd0, 0);
    consume();
    check("perf_ops", perf_ops, 32'd3);
    check("perf_busy", perf_busy, 32'd9);
`endif

    // Randomized ops, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (fn inside {3'd2, 3'd3, 3'd4, 3'd6}) begin
        a = r2f(real'(int'($urandom_range(0, 200)) - 100));
        b = r2f(real'(int'($urandom_range(0, 200)) - 100));
      end
      run_op(fn, a, b, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) consume();
    end
    if (pending) consume();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
